// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan driver.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry n at HEX_SEG[n].
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with per-frame capture,
// anti-ghost blanking and optional leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 2,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lzb_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_start
);

    logic [CNT_W-1:0] cnt;
    digit_idx_t       idx;
    logic [15:0]      frame_val;
    logic [3:0]       frame_dp;
    logic             first;

    logic             slot_end;
    logic             capture;
    logic [3:0]       shamt;
    logic [3:0]       nibble;
    logic [6:0]       hex_seg;
    logic             lead_zero;
    logic             blank_phase;

    assign slot_end    = (cnt == CNT_W'(REFRESH_DIV - 1));
    // First edge after reset also captures so the display never starts stale.
    assign capture     = first || (slot_end && idx == 2'd3);
    assign shamt       = {idx, 2'b00};
    assign nibble      = frame_val[shamt +: 4];
    assign lead_zero   = lzb_en && (idx != 2'd0) && ((frame_val >> shamt) == 16'd0);
    assign blank_phase = (cnt < CNT_W'(BLANK_CYC));

    seg7_hex_decode u_dec (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            first       <= 1'b1;
            frame_val   <= '0;
            frame_dp    <= '0;
            frame_start <= 1'b0;
        end else begin
            first       <= 1'b0;
            frame_start <= capture;
            if (capture) begin
                frame_val <= value;
                frame_dp  <= dp_in;
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (blank_phase) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= lead_zero ? SEG_BLANK : hex_seg;
            dp  <= ~frame_dp[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: per-cycle behavioural model plus literal spot checks.
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] value = 16'h1234;
    logic [3:0]  dp_in = 4'b0000;
    logic        lzb_en = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    seg7_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK), .CNT_W(4)) dut (
        .clk         (clk),
        .RST         (RST),
        .value       (value),
        .dp_in       (dp_in),
        .lzb_en      (lzb_en),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: n edges since reset release; the outputs after edge n describe
    // slot position (n-1) and the frame captured at the previous capture edge.
    int          n = 0;
    logic [15:0] mf = '0;
    logic [3:0]  mdp = '0;
    int          mc, md;
    logic [3:0]  ean;
    logic [6:0]  eseg;
    logic        edp, efs;

    always @(posedge clk) begin
        if (RST) begin
            n = 0; mf = '0; mdp = '0;
            #1 check("reset_out", {an, seg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end else begin
            n++;
            mc  = (n - 1) % DIV;
            md  = ((n - 1) / DIV) % 4;
            efs = (n == 1) || (n % FRAME == 0);
            if (mc < BLANK) begin
                ean = 4'hF; eseg = 7'h7F; edp = 1'b1;
            end else begin
                ean  = 4'hF;
                ean[md] = 1'b0;
                eseg = (lzb_en && md != 0 && (mf >> (4 * md)) == 0) ? 7'h7F : HEX[(mf >> (4 * md)) & 16'hF];
                edp  = ~mdp[md];
            end
            if (efs) begin
                mf = value; mdp = dp_in;
            end
            #1 check("cycle", {an, seg, dp, frame_start}, {ean, eseg, edp, efs});
        end
    end

    task automatic adv(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_fs();
        int i = 0;
        @(negedge clk);
        while (!frame_start && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!frame_start) check("wait_frame_start", 0, 1);
    endtask

    initial begin
        int i;
        logic [15:0] masks [5];
        masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

        // Reset and first frame
        adv(3);
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_dp", dp, 1'b1);
        check("rst_fs", frame_start, 1'b0);
        RST = 1'b0;
        adv(1);
        check("first_fs", frame_start, 1'b1);
        adv(2);
        check("d0_an", an, 4'hE);
        check("d0_seg", seg, 7'h19);
        adv(8);
        check("d1_an", an, 4'hD);
        check("d1_seg", seg, 7'h30);
        adv(8);
        check("d2_an", an, 4'hB);
        check("d2_seg", seg, 7'h24);

        // Tear-free: new value mid-frame shows only from the next frame
        value = 16'hABCD;
        adv(8);
        check("d3_an", an, 4'h7);
        check("d3_seg_old", seg, 7'h79);
        adv(8);
        check("nf_d0_seg", seg, 7'h21);
        adv(8);
        check("nf_d1_seg", seg, 7'h46);

        // Leading-zero blanking
        value = 16'h0070;
        lzb_en = 1'b1;
        wait_fs();
        adv(3);
        check("lz_d0", {an, seg}, {4'hE, 7'h40});
        adv(8);
        check("lz_d1", {an, seg}, {4'hD, 7'h78});
        adv(8);
        check("lz_d2", {an, seg}, {4'hB, 7'h7F});
        adv(8);
        check("lz_d3", {an, seg}, {4'h7, 7'h7F});

        // Zero value with decimal point on digit 2
        value = 16'h0000;
        dp_in = 4'b0100;
        wait_fs();
        adv(3);
        check("z_d0", {an, seg, dp}, {4'hE, 7'h40, 1'b1});
        adv(8);
        check("z_d1", {an, seg, dp}, {4'hD, 7'h7F, 1'b1});
        adv(6);
        check("z_d2_blank", {an, dp}, {4'hF, 1'b1});
        adv(2);
        check("z_d2_dp", {an, seg, dp}, {4'hB, 7'h7F, 1'b0});
        adv(8);
        check("z_d3", {an, dp}, {4'h7, 1'b1});

        // Asynchronous reset while digit 1 is lit
        i = 0;
        while (an != 4'hD && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("found_d1", an, 4'hD);
        #2 RST = 1'b1;
        #1 check("async_blank", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
        adv(2);
        RST = 1'b0;
        adv(1);
        check("rerst_fs", frame_start, 1'b1);
        adv(2);
        check("rerst_d0", {an, seg}, {4'hE, 7'h40});

        // Randomized traffic, checked every cycle by the model
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) value = 16'($urandom) & masks[$urandom_range(0, 4)];
            if ($urandom_range(0, 19) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 29) == 0) lzb_en = ~lzb_en;
        end

        adv(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
